// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter for the UART slave port.
// A watchdog force-completes transactions the slave never acknowledges.
module uart_bus_arbiter #(
  parameter int unsigned        TIMEOUT       = 1024,
  parameter logic [31:0]        TIMEOUT_RDATA = 32'hDEAD_BEEF,
  localparam int unsigned       AW            = 32,
  localparam int unsigned       DW            = 32,
  localparam int unsigned       SW            = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [SW-1:0] m0_wstrb,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [SW-1:0] m1_wstrb,
  output logic [DW-1:0] m1_rdata,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [SW-1:0] s_wstrb,
  input  logic [DW-1:0] s_rdata,
  output logic          timeout_err
);

  localparam int unsigned CW     = 16;
  localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;

  logic            busy;
  logic            g_valid;
  logic            done_ack;
  logic            done_to;
  logic            complete;
  logic [DW-1:0]   ret_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // Ack beats timeout when both land in the same cycle; a dropped valid aborts.
  always_comb begin
    busy     = (state_q == BUSY);
    g_valid  = grant_q ? m1_valid : m0_valid;
    done_ack = busy && g_valid && s_ready;
    done_to  = busy && g_valid && !s_ready && (tcnt_q == TLIMIT);
    complete = done_ack || done_to;
    ret_data = done_ack ? s_rdata : TIMEOUT_RDATA;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tcnt_d       = tcnt_q;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    s_valid      = 1'b0;
    s_addr       = m0_addr;
    s_wdata      = m0_wdata;
    s_wstrb      = m0_wstrb;
    timeout_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
          tcnt_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        tcnt_d = tcnt_q + CW'(1);
        if (grant_q) begin
          s_addr  = m1_addr;
          s_wdata = m1_wdata;
          s_wstrb = m1_wstrb;
        end
        if (!g_valid) begin
          state_d = IDLE;
        end else begin
          s_valid     = 1'b1;
          timeout_err = done_to;
          if (complete) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
            if (grant_q) begin
              m1_ready = 1'b1;
              m1_rdata = ret_data;
            end else begin
              m0_ready = 1'b1;
              m0_rdata = ret_data;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter; completions are checked against a
// scoreboard of expected (master, rdata, timeout) entries.
module tb_uart_bus_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        timeout_err;

  typedef struct {
    logic        m;
    logic [31:0] rd;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] rd, input logic to);
    exp_t e;
    e.m  = m;
    e.rd = rd;
    e.to = to;
    sb.push_back(e);
  endtask

  // Settle combinational outputs, then retire any completion against the scoreboard.
  task automatic sample();
    exp_t e;
    #1;
    if (m0_ready || m1_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'({m1_ready, m0_ready}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ready_master", 32'({m1_ready, m0_ready}), e.m ? 32'd2 : 32'd1);
        chk("rdata", e.m ? m1_rdata : m0_rdata, e.rd);
        chk("other_rdata", e.m ? m0_rdata : m1_rdata, 32'd0);
        chk("timeout_err", 32'(timeout_err), 32'(e.to));
      end
    end else begin
      chk("idle_rdata", m0_rdata | m1_rdata, 32'd0);
      chk("no_timeout", 32'(timeout_err), 32'd0);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    adv();
    adv();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
    m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    do_reset();

    // Reset state
    sample();
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    adv();

    // Single master write, slave acks 3 cycles after s_valid
    m0_valid = 1; m0_addr = 32'h4; m0_wdata = 32'hA5; m0_wstrb = 4'b0001;
    sample();
    chk("s1_idle_s_valid", 32'(s_valid), 32'd0);
    adv();
    sample();
    chk("s1_s_valid", 32'(s_valid), 32'd1);
    chk("s1_s_addr", s_addr, 32'h4);
    chk("s1_s_wdata", s_wdata, 32'hA5);
    chk("s1_s_wstrb", 32'(s_wstrb), 32'h1);
    adv();
    step();
    step();
    s_ready = 1; s_rdata = 32'h55;
    push(1'b0, 32'h55, 1'b0);
    sample();
    chk("s1_m1_ready", 32'(m1_ready), 32'd0);
    adv();
    m0_valid = 0; s_ready = 0;
    sample();
    chk("s1_after_s_valid", 32'(s_valid), 32'd0);
    adv();

    // Contention: strict alternation starting with m0 after reset
    do_reset();
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'hF; m0_wdata = 32'h11;
    m1_valid = 1; m1_addr = 32'h200; m1_wstrb = 4'hF; m1_wdata = 32'h22;
    s_ready = 1;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("c_idle_s_valid", 32'(s_valid), 32'd0);
      adv();
      s_rdata = 32'h100 + 32'(k);
      push(k[0], s_rdata, 1'b0);
      sample();
      chk("c_s_valid", 32'(s_valid), 32'd1);
      chk("c_s_addr", s_addr, k[0] ? 32'h200 : 32'h100);
      adv();
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    step();

    // Read data routing to m1
    m1_valid = 1; m1_addr = 32'h8; m1_wstrb = 4'h0;
    step();
    s_ready = 1; s_rdata = 32'h1234_5678;
    push(1'b1, 32'h1234_5678, 1'b0);
    sample();
    chk("rd_s_wstrb", 32'(s_wstrb), 32'd0);
    adv();
    m1_valid = 0; s_ready = 0;
    step();

    // Timeout on m0 with m1 pending; m0 wins since m1 was served last
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'h0;
    m1_valid = 1; m1_addr = 32'h20; m1_wstrb = 4'h0;
    step();
    for (int i = 1; i < int'(TO); i++) begin
      sample();
      chk("to_wait_s_valid", 32'(s_valid), 32'd1);
      adv();
    end
    push(1'b0, 32'hDEAD_BEEF, 1'b1);
    sample();
    chk("to_fire_s_valid", 32'(s_valid), 32'd1);
    adv();
    m0_valid = 0;
    sample();
    chk("to_after_s_valid", 32'(s_valid), 32'd0);
    adv();
    sample();
    chk("to_next_grant", s_addr, 32'h20);
    adv();
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    push(1'b1, 32'h0BAD_F00D, 1'b0);
    step();
    m1_valid = 0; s_ready = 0;
    step();

    // Ack in the same cycle the watchdog would fire
    m0_valid = 1; m0_addr = 32'h30;
    step();
    for (int i = 1; i < int'(TO); i++) step();
    s_ready = 1; s_rdata = 32'hCAFE_0001;
    push(1'b0, 32'hCAFE_0001, 1'b0);
    step();
    m0_valid = 0; s_ready = 0;
    step();

    // Reset in 2nd BUSY cycle; afterwards first contention grants m0
    m0_valid = 1; m0_addr = 32'h40;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    m1_valid = 1; m1_addr = 32'h50;
    sample();
    chk("rst_mid_s_valid", 32'(s_valid), 32'd0);
    adv();
    chk("rst_mid_grant", s_addr, 32'h40);
    s_ready = 1; s_rdata = 32'h4444;
    push(1'b0, 32'h4444, 1'b0);
    step();
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    step();

    // Abort: granted m1 drops valid mid-BUSY; last_grant must stay at m0
    m1_valid = 1; m1_addr = 32'h60;
    step();
    sample();
    chk("ab_s_valid", 32'(s_valid), 32'd1);
    adv();
    m1_valid = 0;
    sample();
    chk("ab_drop_s_valid", 32'(s_valid), 32'd0);
    adv();
    m0_valid = 1; m0_addr = 32'h70;
    m1_valid = 1; m1_addr = 32'h80;
    step();
    sample();
    chk("ab_next_grant", s_addr, 32'h80);
    adv();
    m0_valid = 0; m1_valid = 0;

    // Late s_ready in IDLE is ignored
    s_ready = 1; s_rdata = 32'h9999;
    sample();
    chk("late_ack_s_valid", 32'(s_valid), 32'd0);
    adv();
    s_ready = 0;
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
